axi_spi_ctrl: RTL and testbench
===============================

// Module: axi_spi_ctrl
// PURPOSE
//  AXI4-Lite slave register front-end directly upstream of the SPI master stage.
//  - Holds SPI config and timing registers and drives them to the master.
//  - Launches one SPI frame per TXDATA write and captures the RXDATA word.
//  - Bridges the master's level-start and busy protocol to a host done/status model.
// PARAMETERS
//  ADDR_W     5      AXI address width; decode uses bits [4:2] only.
//  CTRL_RST   32'h0  CTRL reset value: mode 0, 1/128 speed, 32-bit word.
//  TIMING_RST 24'h0  TIMING reset value: IFG, CS->SCK and SCK->CS all 0.
// PORTS
//  GCLK          in   1       global clock
//  RST_N         in   1       asynchronous reset, active-low
//  s_awvalid/s_awready  in/out 1     AW handshake; s_awaddr in ADDR_W
//  s_wvalid/s_wready    in/out 1     W handshake; s_wdata in 32, s_wstrb in 4
//  s_bvalid/s_bready    out/in 1     B handshake; s_bresp out 2
//  s_arvalid/s_arready  in/out 1     AR handshake; s_araddr in ADDR_W
//  s_rvalid/s_rready    out/in 1     R handshake; s_rdata out 32, s_rresp out 2
//  spi_start_o   out  1       start request to master (level, held until accepted)
//  spi_busy_i    in   1       master busy flag
//  spi_mode_o / sck_speed_o / word_len_o  out 2/2/2   CTRL[1:0]/[3:2]/[5:4]
//  t_ifg_o / t_cs_sck_o / t_sck_cs_o      out 8/8/8   TIMING[7:0]/[15:8]/[23:16]
//  mosi_data_o   out  32      TX word;   miso_data_i  in  32  RX word from master
//  irq_o         out  1       done interrupt; present only with AXI_SPI_IRQ_EN
// BEHAVIOUR
//  Register map: 0x00 CTRL rw, 0x04 TIMING rw, 0x08 TXDATA wo (write starts a frame),
//    0x0C RXDATA ro, 0x10 STATUS: bit0 busy ro, bit1 done W1C, bit2 ie rw (IRQ only).
//  Reset values: all ready/valid outputs 0; resp 0; spi_start_o 0; mosi_data_o 0;
//    RXDATA 0; done 0; ie 0; irq_o 0; CTRL = CTRL_RST; TIMING = TIMING_RST.
//  Write channel:
//    - AW and W are accepted independently, each latched in a 1-deep holding slot.
//    - The register update occurs in the cycle both slots are full.
//    - s_bvalid rises the next cycle and holds until s_bready.
//    - No new AW or W is accepted while s_bvalid is high.
//  Read channel:
//    - s_arready is high when s_rvalid is low.
//    - s_rvalid rises 1 cycle after the AR handshake and holds until s_rready.
//  Byte strobes apply to CTRL, TIMING, TXDATA and STATUS.
//  RXDATA/unmapped writes are ignored with SLVERR; unmapped reads return 0 with SLVERR.
//  Xfer FSM:
//    - IDLE: a TXDATA write latches mosi_data_o and moves to REQ.
//    - REQ: spi_start_o=1 until spi_busy_i=1, then ACT with spi_start_o=0. No timeout;
//      the master defers the start until its IFG expires.
//    - ACT: waits for spi_busy_i to fall, then moves to CAPT.
//    - CAPT: RXDATA<=miso_data_i, done<=1, next IDLE.
//  STATUS.busy = (state != IDLE).
//  Writes to CTRL/TIMING/TXDATA while busy: SLVERR, no register change, no new frame.
//  Same cycle CAPT sets done and a W1C clears it: set wins.
//  Reset mid-frame: FSM returns to IDLE, spi_start_o drops; the master is reset by the same net.
// CONFIGURATION
//  AXI_SPI_IRQ_EN defined:
//    - STATUS.ie is implemented.
//    - irq_o = done & ie, registered, so it asserts 1 cycle after done sets.
//  AXI_SPI_IRQ_EN undefined:
//    - irq_o port is absent.
//    - STATUS bit2 reads 0 and writes to it are ignored.
// STRUCTURE
//  Package axi_spi_pkg:
//    - Register offset localparams.
//    - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
//    - Xfer FSM state enum xfer_state_t {IDLE, REQ, ACT, CAPT}.
//    - CTRL/TIMING field bit positions.
//  Sub-module spi_xfer_seq holds the Xfer FSM, the start/busy handshake and the RX capture.
//    - The top level holds the AXI channels and the register file.
// TESTING
//  1. Reset: read all regs -> CTRL=CTRL_RST, TIMING=TIMING_RST, RXDATA=0, STATUS=0, OKAY.
//  2. Write CTRL=0x35, TIMING=0x040302 -> spi_mode_o=1, sck_speed_o=1, word_len_o=3,
//     t_ifg_o=2, t_cs_sck_o=3, t_sck_cs_o=4.
//  3. TXDATA=0xA5A5_0F0F, master model echoes it back:
//     - spi_start_o is held until busy rises.
//     - STATUS reads 0x1 during the frame, then 0x2.
//     - RXDATA=0xA5A5_0F0F.
//  4. Busy-protection: TXDATA and CTRL writes during an active frame -> SLVERR, CTRL unchanged,
//     exactly 1 frame seen.
//  5. IFG deferral: master holds busy low for 40 cycles -> spi_start_o high for all 40,
//     one frame results.
//  6. AW 3 cycles ahead of W, read of 0x14, W1C done:
//     - Split write completes OKAY.
//     - Read of 0x14 -> 0, SLVERR.
//     - W1C 0x2 clears done.
//     - With AXI_SPI_IRQ_EN: irq_o follows done & ie.

Source files
------------

// File: rtl/axi_spi_pkg.sv
// Shared definitions for the AXI4-Lite SPI register front-end:
// register offsets, response codes, xfer FSM states and field positions.
package axi_spi_pkg;

    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_TIMING = 5'h04;
    localparam logic [4:0] OFF_TXDATA = 5'h08;
    localparam logic [4:0] OFF_RXDATA = 5'h0C;
    localparam logic [4:0] OFF_STATUS = 5'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACT,
        CAPT
    } xfer_state_t;

    localparam int CTRL_MODE_LSB  = 0;
    localparam int CTRL_SPEED_LSB = 2;
    localparam int CTRL_WLEN_LSB  = 4;

    localparam int TIM_IFG_LSB    = 0;
    localparam int TIM_CS_SCK_LSB = 8;
    localparam int TIM_SCK_CS_LSB = 16;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_IE   = 2;

    // Byte-lane merge of write data into an existing register value.
    function automatic logic [31:0] strb_merge(
        input logic [31:0] old_v,
        input logic [31:0] wr_v,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = strb[i] ? wr_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_spi_ctrl_xfer_seq.sv
// Frame sequencer: latches the TX word, runs the level-start / busy
// handshake with the SPI master, then captures RX and flags done.
module spi_xfer_seq
    import axi_spi_pkg::*;
(
    input  logic        GCLK,
    input  logic        RST_N,
    input  logic        tx_we_i,
    input  logic [31:0] tx_wdata_i,
    input  logic [3:0]  tx_wstrb_i,
    input  logic        done_clr_i,
    output logic        spi_start_o,
    input  logic        spi_busy_i,
    input  logic [31:0] miso_data_i,
    output logic [31:0] mosi_data_o,
    output logic [31:0] rx_data_o,
    output logic        done_o,
    output logic        busy_o
);

    xfer_state_t state_q, state_d;
    logic        start_q, start_d;
    logic [31:0] mosi_q, mosi_d;
    logic [31:0] rx_q, rx_d;
    logic        done_q, done_d;

    // Next-state logic; a CAPT set of done overrides a same-cycle clear.
    always_comb begin
        state_d = state_q;
        start_d = start_q;
        mosi_d  = mosi_q;
        rx_d    = rx_q;
        done_d  = done_q;
        if (done_clr_i) done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_we_i) begin
                    mosi_d  = strb_merge(mosi_q, tx_wdata_i, tx_wstrb_i);
                    start_d = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (spi_busy_i) begin
                    start_d = 1'b0;
                    state_d = ACT;
                end
            end
            ACT: begin
                if (!spi_busy_i) state_d = CAPT;
            end
            CAPT: begin
                rx_d    = miso_data_i;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                start_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // FSM and registered outputs.
    always_ff @(posedge GCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            mosi_q  <= '0;
            rx_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            mosi_q  <= mosi_d;
            rx_q    <= rx_d;
            done_q  <= done_d;
        end
    end

    assign spi_start_o = start_q;
    assign mosi_data_o = mosi_q;
    assign rx_data_o   = rx_q;
    assign done_o      = done_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: rtl/axi_spi_ctrl.sv
// AXI4-Lite register front-end for the SPI master stage.
// Optional done interrupt (STATUS.ie, irq_o) under AXI_SPI_IRQ_EN.
module axi_spi_ctrl
    import axi_spi_pkg::*;
#(
    parameter int          ADDR_W     = 5,
    parameter logic [31:0] CTRL_RST   = 32'h0,
    parameter logic [23:0] TIMING_RST = 24'h0
) (
    input  logic              GCLK,
    input  logic              RST_N,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_wvalid,
    output logic              s_wready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic [1:0]        s_bresp,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [ADDR_W-1:0] s_araddr,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              spi_start_o,
    input  logic              spi_busy_i,
    output logic [1:0]        spi_mode_o,
    output logic [1:0]        sck_speed_o,
    output logic [1:0]        word_len_o,
    output logic [7:0]        t_ifg_o,
    output logic [7:0]        t_cs_sck_o,
    output logic [7:0]        t_sck_cs_o,
    output logic [31:0]       mosi_data_o,
    input  logic [31:0]       miso_data_i
`ifdef AXI_SPI_IRQ_EN
    ,
    output logic              irq_o
`endif
);

    logic              rdy_q;
    logic              aw_full_q, aw_full_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
    logic              w_full_q, w_full_d;
    logic [31:0]       w_data_q, w_data_d;
    logic [3:0]        w_strb_q, w_strb_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [31:0]       ctrl_q, ctrl_d;
    logic [23:0]       timing_q, timing_d;

    logic        wr_fire;
    logic [1:0]  wr_resp;
    logic        tx_we;
    logic        done_clr;
    logic        xfer_busy;
    logic        xfer_done;
    logic [31:0] rx_data;
    logic [31:0] tim_m;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        ie_rd;
    logic        unused_bits;

`ifdef AXI_SPI_IRQ_EN
    logic ie_q, ie_d;
    logic irq_q, irq_d;
    assign ie_rd = ie_q;
    assign irq_o = irq_q;
`else
    assign ie_rd = 1'b0;
`endif

    // Readies stay low until the first cycle after reset.
    assign s_awready = rdy_q && !aw_full_q && !bvalid_q;
    assign s_wready  = rdy_q && !w_full_q && !bvalid_q;
    assign s_arready = rdy_q && !rvalid_q;
    assign wr_fire   = aw_full_q && w_full_q;

    // Register write decode, applied when both holding slots are full.
    always_comb begin
        ctrl_d   = ctrl_q;
        timing_d = timing_q;
        tx_we    = 1'b0;
        done_clr = 1'b0;
        wr_resp  = RESP_OKAY;
        tim_m    = strb_merge({8'h00, timing_q}, w_data_q, w_strb_q);
`ifdef AXI_SPI_IRQ_EN
        ie_d     = ie_q;
`endif
        if (wr_fire) begin
            case (aw_addr_q[4:2])
                OFF_CTRL[4:2]: begin
                    if (xfer_busy) wr_resp = RESP_SLVERR;
                    else ctrl_d = strb_merge(ctrl_q, w_data_q, w_strb_q);
                end
                OFF_TIMING[4:2]: begin
                    if (xfer_busy) wr_resp = RESP_SLVERR;
                    else timing_d = tim_m[23:0];
                end
                OFF_TXDATA[4:2]: begin
                    if (xfer_busy) wr_resp = RESP_SLVERR;
                    else tx_we = 1'b1;
                end
                OFF_STATUS[4:2]: begin
                    if (w_strb_q[0]) begin
                        done_clr = w_data_q[STAT_DONE];
`ifdef AXI_SPI_IRQ_EN
                        ie_d = w_data_q[STAT_IE];
`endif
                    end
                end
                default: wr_resp = RESP_SLVERR;
            endcase
        end
    end

    // Read data mux, sampled at the AR handshake.
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (s_araddr[4:2])
            OFF_CTRL[4:2]:   rd_data = ctrl_q;
            OFF_TIMING[4:2]: rd_data = {8'h00, timing_q};
            OFF_TXDATA[4:2]: rd_data = '0;
            OFF_RXDATA[4:2]: rd_data = rx_data;
            OFF_STATUS[4:2]: rd_data = {29'b0, ie_rd, xfer_done, xfer_busy};
            default:         rd_resp = RESP_SLVERR;
        endcase
    end

    // AXI channel next-state: holding slots, B and R response registers.
    always_comb begin
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        if (s_awvalid && s_awready) begin
            aw_full_d = 1'b1;
            aw_addr_d = s_awaddr;
        end
        if (s_wvalid && s_wready) begin
            w_full_d = 1'b1;
            w_data_d = s_wdata;
            w_strb_d = s_wstrb;
        end
        if (bvalid_q && s_bready) bvalid_d = 1'b0;
        if (wr_fire) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_resp;
        end
        if (rvalid_q && s_rready) rvalid_d = 1'b0;
        if (s_arvalid && s_arready) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_data;
            rresp_d  = rd_resp;
        end
    end

`ifdef AXI_SPI_IRQ_EN
    // Interrupt is registered, one cycle behind done & ie.
    always_comb irq_d = xfer_done && ie_q;

    // Interrupt enable and output flops.
    always_ff @(posedge GCLK or negedge RST_N) begin
        if (!RST_N) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            irq_q <= irq_d;
        end
    end
`endif

    // Channel state and register file flops.
    always_ff @(posedge GCLK or negedge RST_N) begin
        if (!RST_N) begin
            rdy_q     <= 1'b0;
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            ctrl_q    <= CTRL_RST;
            timing_q  <= TIMING_RST;
        end else begin
            rdy_q     <= 1'b1;
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            ctrl_q    <= ctrl_d;
            timing_q  <= timing_d;
        end
    end

    spi_xfer_seq u_seq (
        .GCLK        (GCLK),
        .RST_N       (RST_N),
        .tx_we_i     (tx_we),
        .tx_wdata_i  (w_data_q),
        .tx_wstrb_i  (w_strb_q),
        .done_clr_i  (done_clr),
        .spi_start_o (spi_start_o),
        .spi_busy_i  (spi_busy_i),
        .miso_data_i (miso_data_i),
        .mosi_data_o (mosi_data_o),
        .rx_data_o   (rx_data),
        .done_o      (xfer_done),
        .busy_o      (xfer_busy)
    );

    assign s_bvalid = bvalid_q;
    assign s_bresp  = bresp_q;
    assign s_rvalid = rvalid_q;
    assign s_rdata  = rdata_q;
    assign s_rresp  = rresp_q;

    assign spi_mode_o  = ctrl_q[CTRL_MODE_LSB +: 2];
    assign sck_speed_o = ctrl_q[CTRL_SPEED_LSB +: 2];
    assign word_len_o  = ctrl_q[CTRL_WLEN_LSB +: 2];
    assign t_ifg_o     = timing_q[TIM_IFG_LSB +: 8];
    assign t_cs_sck_o  = timing_q[TIM_CS_SCK_LSB +: 8];
    assign t_sck_cs_o  = timing_q[TIM_SCK_CS_LSB +: 8];

    // Address byte-offset bits and unused write lanes are don't-care.
    assign unused_bits = ^{aw_addr_q, s_araddr, w_strb_q, w_data_q};

endmodule

// File: tb/tb_axi_spi_ctrl.sv
// Directed self-checking bench for axi_spi_ctrl with an SPI master model.
// Define AXI_SPI_IRQ_EN to also exercise the interrupt path.
module tb_axi_spi_ctrl;

    logic        GCLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [4:0]  s_awaddr = '0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_bvalid;
    logic        s_bready = 1'b0;
    logic [1:0]  s_bresp;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [4:0]  s_araddr = '0;
    logic        s_rvalid;
    logic        s_rready = 1'b0;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        spi_start_o;
    logic        spi_busy_i = 1'b0;
    logic [1:0]  spi_mode_o;
    logic [1:0]  sck_speed_o;
    logic [1:0]  word_len_o;
    logic [7:0]  t_ifg_o;
    logic [7:0]  t_cs_sck_o;
    logic [7:0]  t_sck_cs_o;
    logic [31:0] mosi_data_o;
    logic [31:0] miso_data_i = '0;
`ifdef AXI_SPI_IRQ_EN
    logic        irq_o;
`endif

    int tests = 0;
    int fails = 0;
    int defer = 0;
    int flen = 5;
    int frames = 0;
    int start_hi = 0;

    axi_spi_ctrl #(
        .ADDR_W     (5),
        .CTRL_RST   (32'h0),
        .TIMING_RST (24'h0)
    ) dut (
        .GCLK        (GCLK),
        .RST_N       (RST_N),
        .s_awvalid   (s_awvalid),
        .s_awready   (s_awready),
        .s_awaddr    (s_awaddr),
        .s_wvalid    (s_wvalid),
        .s_wready    (s_wready),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_bvalid    (s_bvalid),
        .s_bready    (s_bready),
        .s_bresp     (s_bresp),
        .s_arvalid   (s_arvalid),
        .s_arready   (s_arready),
        .s_araddr    (s_araddr),
        .s_rvalid    (s_rvalid),
        .s_rready    (s_rready),
        .s_rdata     (s_rdata),
        .s_rresp     (s_rresp),
        .spi_start_o (spi_start_o),
        .spi_busy_i  (spi_busy_i),
        .spi_mode_o  (spi_mode_o),
        .sck_speed_o (sck_speed_o),
        .word_len_o  (word_len_o),
        .t_ifg_o     (t_ifg_o),
        .t_cs_sck_o  (t_cs_sck_o),
        .t_sck_cs_o  (t_sck_cs_o),
        .mosi_data_o (mosi_data_o),
        .miso_data_i (miso_data_i)
`ifdef AXI_SPI_IRQ_EN
        ,
        .irq_o       (irq_o)
`endif
    );

    always #5 GCLK = ~GCLK;

    // Count cycles with the start request raised.
    always @(negedge GCLK) if (spi_start_o) start_hi++;

    // SPI master model: defers by 'defer' cycles, busy for 'flen', echoes TX.
    initial begin
        forever begin
            @(negedge GCLK);
            if (RST_N && spi_start_o) begin
                repeat (defer) @(negedge GCLK);
                spi_busy_i = 1'b1;
                frames++;
                repeat (flen) @(negedge GCLK);
                miso_data_i = mosi_data_o;
                spi_busy_i = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                             input logic [3:0] st, input int lead,
                             output logic [1:0] resp);
        bit aw_done, w_done, hs_aw, hs_w;
        int gap, cyc;
        @(negedge GCLK);
        s_awaddr  = a;
        s_awvalid = 1'b1;
        s_wdata   = d;
        s_wstrb   = st;
        s_wvalid  = (lead == 0);
        aw_done = 0; w_done = 0; gap = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 200) begin
            hs_aw = s_awvalid && s_awready;
            hs_w  = s_wvalid && s_wready;
            @(negedge GCLK);
            cyc++;
            if (hs_aw) begin s_awvalid = 1'b0; aw_done = 1; end
            if (hs_w) begin s_wvalid = 1'b0; w_done = 1; end
            if (aw_done && !w_done && !s_wvalid) begin
                if (gap >= lead - 1) s_wvalid = 1'b1;
                else gap++;
            end
        end
        chk("aw_w_handshake", {31'b0, aw_done && w_done}, 32'd1);
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b1;
        cyc = 0;
        while (!s_bvalid && cyc < 50) begin @(negedge GCLK); cyc++; end
        chk("b_timeout", {31'b0, s_bvalid}, 32'd1);
        resp = s_bresp;
        @(negedge GCLK);
        s_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
        int cyc;
        @(negedge GCLK);
        s_araddr  = a;
        s_arvalid = 1'b1;
        cyc = 0;
        while (!s_arready && cyc < 50) begin @(negedge GCLK); cyc++; end
        @(negedge GCLK);
        s_arvalid = 1'b0;
        s_rready  = 1'b1;
        cyc = 0;
        while (!s_rvalid && cyc < 50) begin @(negedge GCLK); cyc++; end
        chk("r_timeout", {31'b0, s_rvalid}, 32'd1);
        d    = s_rdata;
        resp = s_rresp;
        @(negedge GCLK);
        s_rready = 1'b0;
    endtask

    task automatic wait_idle();
        logic [31:0] st;
        logic [1:0]  r;
        int n;
        n = 0;
        st = 32'h1;
        while (st[0] && n < 200) begin
            axi_read(5'h10, st, r);
            n++;
        end
        chk("idle_timeout", {31'b0, st[0]}, 32'd0);
    endtask

    logic [31:0] rd;
    logic [1:0]  rr;
    logic [1:0]  br;
    int          f0;

    initial begin
        // Reset
        repeat (3) @(negedge GCLK);
        chk("rst_awready", {31'b0, s_awready}, 32'd0);
        chk("rst_arready", {31'b0, s_arready}, 32'd0);
        chk("rst_start", {31'b0, spi_start_o}, 32'd0);
        chk("rst_bvalid", {31'b0, s_bvalid}, 32'd0);
        chk("rst_rvalid", {31'b0, s_rvalid}, 32'd0);
        chk("rst_mosi", mosi_data_o, 32'h0);
        RST_N = 1'b1;
        axi_read(5'h00, rd, rr);
        chk("rst_ctrl", rd, 32'h0);
        chk("rst_ctrl_resp", {30'b0, rr}, 32'd0);
        axi_read(5'h04, rd, rr);
        chk("rst_timing", rd, 32'h0);
        axi_read(5'h0C, rd, rr);
        chk("rst_rxdata", rd, 32'h0);
        axi_read(5'h10, rd, rr);
        chk("rst_status", rd, 32'h0);
        chk("rst_status_resp", {30'b0, rr}, 32'd0);

        // Config registers
        axi_write(5'h00, 32'h35, 4'hF, 0, br);
        chk("ctrl_wr_resp", {30'b0, br}, 32'd0);
        axi_write(5'h04, 32'h040302, 4'hF, 0, br);
        chk("tim_wr_resp", {30'b0, br}, 32'd0);
        chk("spi_mode", {30'b0, spi_mode_o}, 32'd1);
        chk("sck_speed", {30'b0, sck_speed_o}, 32'd1);
        chk("word_len", {30'b0, word_len_o}, 32'd3);
        chk("t_ifg", {24'b0, t_ifg_o}, 32'd2);
        chk("t_cs_sck", {24'b0, t_cs_sck_o}, 32'd3);
        chk("t_sck_cs", {24'b0, t_sck_cs_o}, 32'd4);
        axi_read(5'h04, rd, rr);
        chk("tim_readback", rd, 32'h040302);

        // Single frame with echo
        defer = 0; flen = 20; start_hi = 0;
        axi_write(5'h08, 32'hA5A5_0F0F, 4'hF, 0, br);
        chk("tx_wr_resp", {30'b0, br}, 32'd0);
        chk("tx_mosi", mosi_data_o, 32'hA5A5_0F0F);
        axi_read(5'h10, rd, rr);
        chk("status_busy", rd, 32'h1);
        wait_idle();
        axi_read(5'h10, rd, rr);
        chk("status_done", rd, 32'h2);
        axi_read(5'h0C, rd, rr);
        chk("rxdata_echo", rd, 32'hA5A5_0F0F);
        chk("frame1_count", frames, 32'd1);
        chk("frame1_start_cyc", start_hi, 32'd1);

        // Busy protection
        flen = 30; f0 = frames;
        axi_write(5'h08, 32'h0000_1234, 4'hF, 0, br);
        chk("tx2_resp", {30'b0, br}, 32'd0);
        axi_write(5'h08, 32'hDEAD_BEEF, 4'hF, 0, br);
        chk("tx_busy_resp", {30'b0, br}, 32'd2);
        axi_write(5'h00, 32'h0, 4'hF, 0, br);
        chk("ctrl_busy_resp", {30'b0, br}, 32'd2);
        axi_read(5'h00, rd, rr);
        chk("ctrl_kept", rd, 32'h35);
        chk("mosi_kept", mosi_data_o, 32'h0000_1234);
        axi_write(5'h0C, 32'hFFFF_FFFF, 4'hF, 0, br);
        chk("rx_wr_resp", {30'b0, br}, 32'd2);
        wait_idle();
        chk("busy_frames", frames - f0, 32'd1);

        // IFG deferral
        defer = 40; flen = 3; start_hi = 0; f0 = frames;
        axi_write(5'h08, 32'h0000_005A, 4'hF, 0, br);
        wait_idle();
        chk("defer_start_cyc", start_hi, 32'd41);
        chk("defer_frames", frames - f0, 32'd1);
        axi_read(5'h0C, rd, rr);
        chk("defer_rxdata", rd, 32'h5A);

        // Split write, strobes, unmapped read, W1C
        defer = 0;
        axi_write(5'h04, 32'h000A_0B0C, 4'hF, 3, br);
        chk("split_resp", {30'b0, br}, 32'd0);
        chk("split_ifg", {24'b0, t_ifg_o}, 32'h0C);
        chk("split_cs_sck", {24'b0, t_cs_sck_o}, 32'h0B);
        chk("split_sck_cs", {24'b0, t_sck_cs_o}, 32'h0A);
        axi_write(5'h00, 32'hFFFF_FF3A, 4'h1, 0, br);
        axi_read(5'h00, rd, rr);
        chk("ctrl_strb", rd, 32'h3A);
        chk("strb_mode", {30'b0, spi_mode_o}, 32'd2);
        axi_read(5'h14, rd, rr);
        chk("unmap_data", rd, 32'h0);
        chk("unmap_resp", {30'b0, rr}, 32'd2);
        axi_write(5'h10, 32'h4, 4'hF, 0, br);
        axi_read(5'h10, rd, rr);
`ifdef AXI_SPI_IRQ_EN
        chk("status_ie", rd, 32'h6);
        chk("irq_set", {31'b0, irq_o}, 32'd1);
`else
        chk("status_no_ie", rd, 32'h2);
`endif
        axi_write(5'h10, 32'h6, 4'hF, 0, br);
        axi_read(5'h10, rd, rr);
`ifdef AXI_SPI_IRQ_EN
        chk("w1c_status", rd, 32'h4);
        chk("irq_clr", {31'b0, irq_o}, 32'd0);
`else
        chk("w1c_status", rd, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
